// File: rtl/byte_decode_kem_pkg.sv
// Shared types and constants for the streaming ByteDecode_d unpacker.
package byte_decode_kem_pkg;

    // ML-KEM prime modulus; decoded 12-bit coefficients must stay below it.
    localparam int unsigned ML_KEM_Q          = 3329;
    localparam int unsigned BD_COEFS_PER_POLY = 256;
    localparam int unsigned BD_WORD_W         = 64;
    localparam int unsigned BD_BUF_W          = 128;
    localparam int unsigned BD_CNT_W          = 8;

    typedef enum logic [1:0] {
        BD_IDLE,
        BD_RUN,
        BD_DONE
    } byte_decode_state_t;

    // Low-order mask of 'width' ones, width in 1..12.
    function automatic logic [11:0] bd_mask(input logic [3:0] width);
        return 12'((13'd1 << width) - 13'd1);
    endfunction

endpackage

// File: rtl/byte_decode_kem_unpacker.sv
// 128-bit bit buffer: words are appended above the current fill level,
// coefficients are taken from bit 0. Caller guarantees push only when
// cnt <= 64 and pop only when cnt >= width, so the buffer never overflows
// or underflows. Bits above cnt are always zero, which lets insertion be an OR.
module bit_unpacker_128
    import byte_decode_kem_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [3:0]           width_i,
    input  logic [BD_WORD_W-1:0] din_i,
    output logic [11:0]          data_o,
    output logic [BD_CNT_W-1:0]  cnt_o
);

    logic [BD_BUF_W-1:0] r_buf;
    logic [BD_CNT_W-1:0] r_cnt;

    logic [BD_BUF_W-1:0] w_shifted;
    logic [BD_BUF_W-1:0] w_ins;
    logic [BD_BUF_W-1:0] w_buf_next;
    logic [BD_CNT_W-1:0] w_base;
    logic [BD_CNT_W-1:0] w_cnt_next;

    // Next buffer: drop the popped coefficient first, then place the new
    // word directly above whatever remains.
    always_comb begin
        w_shifted  = pop_i ? (r_buf >> width_i) : r_buf;
        w_base     = pop_i ? (r_cnt - {4'd0, width_i}) : r_cnt;
        w_ins      = {{(BD_BUF_W - BD_WORD_W){1'b0}}, din_i} << w_base;
        w_buf_next = push_i ? (w_shifted | w_ins) : w_shifted;
        w_cnt_next = w_base + (push_i ? 8'(BD_WORD_W) : 8'd0);
    end

    // Buffer and fill-count registers; held while neither side transfers.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (push_i || pop_i) begin
            r_buf <= w_buf_next;
            r_cnt <= w_cnt_next;
        end
    end

    assign data_o = r_buf[11:0] & bd_mask(width_i);
    assign cnt_o  = r_cnt;

endmodule

// File: rtl/byte_decode_kem.sv
// Streaming ByteDecode_d: unpacks little-endian 64-bit words into d-bit
// coefficients for K_POLY polynomials of 256 coefficients each, with a
// sticky modulus check when d = 12.
module byte_decode_kem
    import byte_decode_kem_pkg::*;
#(
    parameter int unsigned D      = 12,
    parameter int unsigned K_POLY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    input  logic [63:0] din_i,
    input  logic        din_valid_i,
    output logic        din_ready_o,
    output logic [11:0] coef_o,
    output logic [7:0]  coef_idx_o,
    output logic [3:0]  poly_idx_o,
    output logic        coef_valid_o,
    input  logic        coef_ready_i,
    output logic        done_o,
    output logic        err_o
);

    // A polynomial is 256*D bits = 4*D words; polynomials never share a word.
    localparam int unsigned JOB_WORDS = 4 * D * K_POLY;
    localparam logic [3:0]  W_D       = 4'(D);
    localparam logic [15:0] W_JOB     = 16'(JOB_WORDS);
    localparam logic [7:0]  LAST_COEF = 8'(BD_COEFS_PER_POLY - 1);
    localparam logic [3:0]  LAST_POLY = 4'(K_POLY - 1);
    localparam bit          CHECK_Q   = (D == 12);

    byte_decode_state_t r_state;
    byte_decode_state_t w_state_next;

    logic [15:0]         r_words_left;
    logic [7:0]          r_coef_idx;
    logic [3:0]          r_poly_idx;
    logic                r_err;

    logic [11:0]         w_coef;
    logic [BD_CNT_W-1:0] w_cnt;
    logic                w_run;
    logic                w_start;
    logic                w_push;
    logic                w_pop;
    logic                w_last;
    logic                w_coef_bad;

    // Handshake and control decode from the current state and buffer level.
    always_comb begin
        w_run        = (r_state == BD_RUN);
        w_start      = (r_state == BD_IDLE) && start_i;
        din_ready_o  = w_run && (r_words_left != 16'd0) && (w_cnt <= 8'(BD_WORD_W));
        coef_valid_o = w_run && (w_cnt >= {4'd0, W_D});
        w_push       = din_valid_i && din_ready_o;
        w_pop        = coef_valid_o && coef_ready_i;
        w_last       = (r_coef_idx == LAST_COEF) && (r_poly_idx == LAST_POLY);
        w_coef_bad   = CHECK_Q && (w_coef >= 12'(ML_KEM_Q));
    end

    bit_unpacker_128 u_unpacker (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (w_start),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .width_i (W_D),
        .din_i   (din_i),
        .data_o  (w_coef),
        .cnt_o   (w_cnt)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= BD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a job ends on the final coefficient transfer; DONE lasts one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BD_IDLE: if (start_i)          w_state_next = BD_RUN;
            BD_RUN:  if (w_pop && w_last)  w_state_next = BD_DONE;
            BD_DONE:                       w_state_next = BD_IDLE;
            default:                       w_state_next = BD_IDLE;
        endcase
    end

    // Word budget, coefficient/polynomial indices and sticky modulus flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_words_left <= '0;
            r_coef_idx   <= '0;
            r_poly_idx   <= '0;
            r_err        <= 1'b0;
        end else if (w_start) begin
            r_words_left <= W_JOB;
            r_coef_idx   <= '0;
            r_poly_idx   <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_push) begin
                r_words_left <= r_words_left - 16'd1;
            end
            if (w_pop) begin
                r_coef_idx <= r_coef_idx + 8'd1;
                if (w_last) begin
                    r_poly_idx <= '0;
                end else if (r_coef_idx == LAST_COEF) begin
                    r_poly_idx <= r_poly_idx + 4'd1;
                end
                if (w_coef_bad) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign busy_o     = (r_state != BD_IDLE);
    assign done_o     = (r_state == BD_DONE);
    assign err_o      = r_err;
    assign coef_o     = w_coef;
    assign coef_idx_o = r_coef_idx;
    assign poly_idx_o = r_poly_idx;

endmodule

// File: tb/tb_byte_decode_kem.sv
// Directed bench for byte_decode_kem across four parameter sets:
// 0: D=12 K=1, 1: D=12 K=3, 2: D=1 K=1, 3: D=10 K=2.
module tb_byte_decode_kem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [4];
    logic        start [4];
    logic        dv    [4];
    logic [63:0] din   [4];
    logic        cr    [4];
    logic        busy  [4];
    logic        drdy  [4];
    logic [11:0] coef  [4];
    logic [7:0]  cidx  [4];
    logic [3:0]  pidx  [4];
    logic        cv    [4];
    logic        done  [4];
    logic        err   [4];

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] w_q[$];
    int          e_q[$];

    byte_decode_kem #(.D(12), .K_POLY(1)) u_d12k1 (
        .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .busy_o(busy[0]),
        .din_i(din[0]), .din_valid_i(dv[0]), .din_ready_o(drdy[0]),
        .coef_o(coef[0]), .coef_idx_o(cidx[0]), .poly_idx_o(pidx[0]),
        .coef_valid_o(cv[0]), .coef_ready_i(cr[0]), .done_o(done[0]), .err_o(err[0]));

    byte_decode_kem #(.D(12), .K_POLY(3)) u_d12k3 (
        .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .busy_o(busy[1]),
        .din_i(din[1]), .din_valid_i(dv[1]), .din_ready_o(drdy[1]),
        .coef_o(coef[1]), .coef_idx_o(cidx[1]), .poly_idx_o(pidx[1]),
        .coef_valid_o(cv[1]), .coef_ready_i(cr[1]), .done_o(done[1]), .err_o(err[1]));

    byte_decode_kem #(.D(1), .K_POLY(1)) u_d1k1 (
        .clk_i(clk), .rst_i(rst[2]), .start_i(start[2]), .busy_o(busy[2]),
        .din_i(din[2]), .din_valid_i(dv[2]), .din_ready_o(drdy[2]),
        .coef_o(coef[2]), .coef_idx_o(cidx[2]), .poly_idx_o(pidx[2]),
        .coef_valid_o(cv[2]), .coef_ready_i(cr[2]), .done_o(done[2]), .err_o(err[2]));

    byte_decode_kem #(.D(10), .K_POLY(2)) u_d10k2 (
        .clk_i(clk), .rst_i(rst[3]), .start_i(start[3]), .busy_o(busy[3]),
        .din_i(din[3]), .din_valid_i(dv[3]), .din_ready_o(drdy[3]),
        .coef_o(coef[3]), .coef_idx_o(cidx[3]), .poly_idx_o(pidx[3]),
        .coef_valid_o(cv[3]), .coef_ready_i(cr[3]), .done_o(done[3]), .err_o(err[3]));

    // Reference ByteEncode_d: stream bit p is bit (p mod d) of coefficient p/d.
    task automatic build_stream(input int d);
        int          nbits;
        int          pos;
        int          tmp;
        logic [63:0] w;
        w_q.delete();
        nbits = e_q.size() * d;
        for (int wi = 0; wi < nbits / 64; wi++) begin
            w = '0;
            for (int b = 0; b < 64; b++) begin
                pos  = wi * 64 + b;
                tmp  = e_q[pos / d];
                w[b] = tmp[pos % d];
            end
            w_q.push_back(w);
        end
    endtask

    task automatic check_zero(input int u, input string name);
        n_chk++;
        if (busy[u] !== 1'b0 || drdy[u] !== 1'b0 || cv[u] !== 1'b0 || done[u] !== 1'b0 ||
            err[u] !== 1'b0 || coef[u] !== 12'd0 || cidx[u] !== 8'd0 || pidx[u] !== 4'd0) begin
            n_fail++;
            $display("FAIL %s u%0d: busy=%b rdy=%b valid=%b done=%b err=%b coef=%h idx=%0d poly=%0d, required all 0",
                     name, u, busy[u], drdy[u], cv[u], done[u], err[u], coef[u], cidx[u], pidx[u]);
        end
    endtask

    // Runs one job on instance u with the stream in w_q and golden coefs in e_q.
    task automatic run_job(input int u, input int vprob, input int rprob, input bit exp_err,
                           input bit extra, input bit restart, input int abort_at,
                           input int exp_cycles, input string name);
        int          n, wi, nw, total, extra_acc, first_acc, first_cv, end_cyc;
        bit          prev_stall, early_done;
        logic [11:0] prev_coef;
        nw = w_q.size(); total = e_q.size();
        n = 0; wi = 0; extra_acc = 0; first_acc = -1; first_cv = -1; end_cyc = -1;
        prev_stall = 1'b0; early_done = 1'b0; prev_coef = '0;
        @(negedge clk);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        n_chk++;
        if (busy[u] !== 1'b1 || cv[u] !== 1'b0 || cidx[u] !== 8'd0 || pidx[u] !== 4'd0) begin
            n_fail++;
            $display("FAIL %s start: busy=%b valid=%b idx=%0d poly=%0d, required 1 0 0 0",
                     name, busy[u], cv[u], cidx[u], pidx[u]);
        end
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (prev_stall) begin
                n_chk++;
                if (cv[u] !== 1'b1 || coef[u] !== prev_coef) begin
                    n_fail++;
                    $display("FAIL %s stall hold at coef %0d: valid=%b coef=%h, required 1 %h",
                             name, n, cv[u], coef[u], prev_coef);
                end
            end
            if (first_cv < 0 && cv[u] === 1'b1) first_cv = cyc;
            if (n == total || (abort_at >= 0 && n == abort_at)) begin
                end_cyc = cyc;
                break;
            end
            if (done[u] === 1'b1) early_done = 1'b1;
            start[u] = restart && cyc >= 5 && cyc < 25;
            if (wi < nw) begin
                dv[u]  = ($urandom_range(99) < vprob);
                din[u] = w_q[wi];
            end else begin
                dv[u]  = extra;
                din[u] = 64'hA5A5_5A5A_F00D_CAFE;
            end
            cr[u] = ($urandom_range(99) < rprob);
            if (dv[u] && drdy[u] === 1'b1) begin
                if (wi < nw) begin
                    if (first_acc < 0) first_acc = cyc;
                    wi++;
                end else begin
                    extra_acc++;
                end
            end
            prev_stall = (cv[u] === 1'b1) && !cr[u];
            prev_coef  = coef[u];
            if (cv[u] === 1'b1 && cr[u]) begin
                n_chk++;
                if (coef[u] !== 12'(e_q[n]) || cidx[u] !== 8'(n % 256) || pidx[u] !== 4'(n / 256)) begin
                    n_fail++;
                    $display("FAIL %s coef %0d: got %h idx %0d poly %0d, required %h idx %0d poly %0d",
                             name, n, coef[u], cidx[u], pidx[u], 12'(e_q[n]), n % 256, n / 256);
                end
                n++;
            end
            @(negedge clk);
        end
        start[u] = 1'b0;
        if (end_cyc < 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s timeout: %0d of %0d coefs transferred", name, n, total);
            dv[u] = 1'b0; cr[u] = 1'b0;
            return;
        end
        n_chk++;
        if (first_cv != first_acc + 1) begin
            n_fail++;
            $display("FAIL %s latency: first valid cycle %0d, required %0d", name, first_cv, first_acc + 1);
        end
        if (abort_at >= 0) begin
            dv[u] = 1'b0; cr[u] = 1'b0;
            return;
        end
        n_chk++;
        if (done[u] !== 1'b1 || early_done) begin
            n_fail++;
            $display("FAIL %s done: got %b (early=%b), required 1 after last coef", name, done[u], early_done);
        end
        n_chk++;
        if (err[u] !== exp_err) begin
            n_fail++;
            $display("FAIL %s err: got %b, required %b", name, err[u], exp_err);
        end
        n_chk++;
        if (wi != nw || extra_acc != 0) begin
            n_fail++;
            $display("FAIL %s words: accepted %0d extra %0d, required %0d extra 0", name, wi, extra_acc, nw);
        end
        n_chk++;
        if (drdy[u] !== 1'b0 || cv[u] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done handshake: ready=%b valid=%b, required 0 0", name, drdy[u], cv[u]);
        end
        if (exp_cycles > 0) begin
            n_chk++;
            if (end_cyc != exp_cycles) begin
                n_fail++;
                $display("FAIL %s throughput: %0d cycles, required %0d", name, end_cyc, exp_cycles);
            end
        end
        cr[u] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (done[u] !== 1'b0 || busy[u] !== 1'b0 || cv[u] !== 1'b0 || drdy[u] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s idle %0d: done=%b busy=%b valid=%b ready=%b, required 0 0 0 0",
                         name, i, done[u], busy[u], cv[u], drdy[u]);
            end
        end
        dv[u] = 1'b0;
        cr[u] = 1'b0;
    endtask

    task automatic test_reset();
        for (int u = 0; u < 4; u++) begin
            rst[u] = 1'b1; start[u] = 1'b0; dv[u] = 1'b0; din[u] = '0; cr[u] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 4; u++) check_zero(u, "reset");
        for (int u = 0; u < 4; u++) rst[u] = 1'b0;
    endtask

    task automatic test_all_ones();
        e_q.delete(); w_q.delete();
        for (int i = 0; i < 256; i++) e_q.push_back(12'hFFF);
        for (int i = 0; i < 48; i++) w_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        run_job(0, 100, 100, 1'b1, 1'b0, 1'b0, -1, 257, "all_ones");
    endtask

    task automatic test_modulus_boundary();
        e_q.delete();
        for (int i = 0; i < 256; i++) e_q.push_back((i == 17) ? 3328 : (i * 13) % 3329);
        build_stream(12);
        run_job(0, 100, 100, 1'b0, 1'b0, 1'b0, -1, 0, "q_minus_1");
        e_q.delete();
        for (int i = 0; i < 256; i++) e_q.push_back((i == 200) ? 3329 : (i * 13) % 3329);
        build_stream(12);
        run_job(0, 100, 100, 1'b1, 1'b0, 1'b0, -1, 0, "q_exact");
    endtask

    task automatic test_three_polys();
        e_q.delete();
        for (int i = 0; i < 768; i++) e_q.push_back(i % 3329);
        build_stream(12);
        run_job(1, 100, 100, 1'b0, 1'b0, 1'b0, -1, 769, "three_polys");
    endtask

    task automatic test_d1();
        e_q.delete(); w_q.delete();
        for (int i = 0; i < 256; i++) e_q.push_back((i == 0 || i == 2) ? 1 : 0);
        w_q.push_back(64'h0000_0000_0000_0005);
        for (int i = 0; i < 3; i++) w_q.push_back(64'h0);
        run_job(2, 100, 100, 1'b0, 1'b1, 1'b0, -1, 257, "d1");
    endtask

    task automatic test_d10_backpressure();
        e_q.delete();
        for (int i = 0; i < 512; i++) e_q.push_back($urandom_range(1023));
        build_stream(10);
        run_job(3, 60, 50, 1'b0, 1'b0, 1'b0, -1, 0, "d10_random");
    endtask

    task automatic test_reset_mid_job();
        e_q.delete();
        for (int i = 0; i < 768; i++) e_q.push_back(i % 3329);
        build_stream(12);
        run_job(1, 100, 100, 1'b0, 1'b0, 1'b0, 100, 0, "abort");
        rst[1] = 1'b1;
        @(negedge clk);
        check_zero(1, "mid_reset");
        rst[1] = 1'b0;
        e_q.delete();
        for (int i = 0; i < 768; i++) e_q.push_back((i == 500) ? 4000 : (i * 7 + 11) % 3329);
        build_stream(12);
        run_job(1, 80, 80, 1'b1, 1'b0, 1'b0, -1, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        e_q.delete();
        for (int i = 0; i < 512; i++) e_q.push_back((i * 37 + 5) % 1024);
        build_stream(10);
        run_job(3, 100, 100, 1'b0, 1'b1, 1'b1, -1, 513, "restart_extra");
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_modulus_boundary();
        test_three_polys();
        test_d1();
        test_d10_backpressure();
        test_reset_mid_job();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
